// File: rtl/i_fill_pkg.sv
// Shared definitions for the instruction-cache line fill controller:
// default geometry, legal instruction address window, burst timeout and
// the FSM state encoding.
package i_fill_pkg;

    localparam int unsigned DEF_LINE_WORDS = 16;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0001_0000;
    localparam logic [31:0] DEF_IMEM_LIMIT = 32'h0001_01FF;
    localparam int unsigned DEF_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BURST = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_ERR   = 3'd5
    } fill_state_e;

    // Inclusive window check used for the miss address.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/i_fill_ctrl_if.sv
// Bundle of the cache-side and memory-side signals of the fill controller.
//
// Handshakes:
//   - miss_req is a level held by the cache until it sees line_wr_en.
//   - mem_rd_req/mem_rd_addr are held stable until the cycle in which
//     mem_rd_gnt is high; that cycle completes the request.
//   - mem_rd_valid marks one burst beat per cycle, in address order; there
//     is no backpressure, the controller takes every beat it is offered.
//   - line_wr_en is a one-cycle strobe; line_addr/line_data are only
//     meaningful while it is high.
interface i_fill_ctrl_if
    import i_fill_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
);
    logic                         miss_req;
    logic [31:0]                  miss_addr;
    logic [LINE_WORDS-1:0][31:0]  line_data;
    logic [31:0]                  line_addr;
    logic                         line_wr_en;
    logic                         fill_busy;
    logic                         fill_err;
    logic                         mem_rd_req;
    logic [31:0]                  mem_rd_addr;
    logic                         mem_rd_gnt;
    logic                         mem_rd_valid;
    logic [31:0]                  mem_rd_data;

    // Controller side.
    modport slave (
        input  miss_req, miss_addr, mem_rd_gnt, mem_rd_valid, mem_rd_data,
        output line_data, line_addr, line_wr_en, fill_busy, fill_err,
               mem_rd_req, mem_rd_addr
    );

    // Cache/memory side.
    modport master (
        output miss_req, miss_addr, mem_rd_gnt, mem_rd_valid, mem_rd_data,
        input  line_data, line_addr, line_wr_en, fill_busy, fill_err,
               mem_rd_req, mem_rd_addr
    );

endinterface

// File: rtl/i_line_buf.sv
// Beat buffer for one cache line: one write port indexed by beat number and
// a parallel read-out. The read-out forwards the word being written so the
// final beat is visible in the same cycle it arrives.
module i_line_buf
    import i_fill_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
    input  logic [31:0]                   wr_data_i,
    output logic [LINE_WORDS-1:0][31:0]   rd_line_o
);

    logic [LINE_WORDS-1:0][31:0] mem_q;

    // Store one beat per write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Parallel read-out with write-through of the current beat.
    always_comb begin
        rd_line_o = mem_q;
        if (wr_en_i) begin
            rd_line_o[wr_idx_i] = wr_data_i;
        end
    end

endmodule

// File: rtl/i_fill_ctrl.sv
// Instruction-cache line fill controller. On a miss inside the legal
// instruction window it issues one burst read for the aligned line,
// collects LINE_WORDS beats, writes the line to the cache with a single
// strobe, then waits one cycle so the cache can mark the line valid.
// Out-of-range misses and stalled bursts park the block in a sticky error
// state until reset.
module i_fill_ctrl
    import i_fill_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_LIMIT = DEF_IMEM_LIMIT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    i_fill_ctrl_if.slave   bus,
    output logic [2:0]     dbg_state_o
);

    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_REQ   = ST_REQ;
    localparam logic [2:0] S_BURST = ST_BURST;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_ERR   = ST_ERR;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    // Idle count seen in the last silent cycle before the fault fires.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [2:0]                  state_q, state_d;
    logic [31:0]                 base_q, base_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [IDLE_W-1:0]           idle_q, idle_d;
    logic [31:0]                 line_addr_q;
    logic [LINE_WORDS-1:0][31:0] line_data_q;
    logic                        buf_we;
    logic                        load_line;
    logic [LINE_WORDS-1:0][31:0] buf_line;
    logic                        addr_ok;
    logic [31:0]                 miss_base;

    assign addr_ok   = addr_in_range(bus.miss_addr, IMEM_BASE, IMEM_LIMIT);
    assign miss_base = {bus.miss_addr[31:BEAT_W], {BEAT_W{1'b0}}};

    i_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_we),
        .wr_idx_i  (beat_q),
        .wr_data_i (bus.mem_rd_data),
        .rd_line_o (buf_line)
    );

    // Next-state logic: FSM, beat counter, idle watchdog and base latch.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        buf_we    = 1'b0;
        load_line = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_req) begin
                    if (addr_ok) begin
                        base_d  = miss_base;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_rd_gnt) begin
                    beat_d  = '0;
                    idle_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // A beat always wins over the watchdog, even on its last cycle.
                if (bus.mem_rd_valid) begin
                    buf_we = 1'b1;
                    idle_d = '0;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        load_line = 1'b1;
                        state_d   = S_WRITE;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_WRITE: state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
        end
    end

    // Line output registers: loaded on the final beat so they hold steady
    // while the next burst refills the beat buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr_q <= '0;
            line_data_q <= '0;
        end else if (load_line) begin
            line_addr_q <= base_q;
            line_data_q <= buf_line;
        end
    end

    assign bus.mem_rd_req  = (state_q == S_REQ);
    assign bus.mem_rd_addr = base_q;
    assign bus.line_wr_en  = (state_q == S_WRITE);
    assign bus.line_addr   = line_addr_q;
    assign bus.line_data   = line_data_q;
    assign bus.fill_busy   = (state_q != S_IDLE) && (state_q != S_ERR);
    assign bus.fill_err    = (state_q == S_ERR);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_i_fill_ctrl.sv
// Directed bench for i_fill_ctrl: a vector table for single-cycle control
// behaviour and address-window edges, plus hand sequences for full fills,
// gapped bursts, the burst watchdog, reset mid-burst and back-to-back misses.
module tb_i_fill_ctrl;
    import i_fill_pkg::*;

    localparam int LW = DEF_LINE_WORDS;
    localparam int TO = DEF_TIMEOUT;

    // Status nibble: {mem_rd_req, line_wr_en, fill_busy, fill_err}
    localparam logic [3:0] ST_Z   = 4'b0000;
    localparam logic [3:0] ST_RQ  = 4'b1010;
    localparam logic [3:0] ST_BSY = 4'b0010;
    localparam logic [3:0] ST_WR  = 4'b0110;
    localparam logic [3:0] ST_ER  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    i_fill_ctrl_if bus ();

    i_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.miss_req     = 1'b0;
        bus.miss_addr    = '0;
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (state %0d, t=%0t)", name, act, exp, dbg_state, $time);
        end
    endtask

    function automatic logic [31:0] status();
        return {28'd0, bus.mem_rd_req, bus.line_wr_en, bus.fill_busy, bus.fill_err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_fill(input logic [31:0] addr, input logic [31:0] exp_base, input int n_wait);
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        step();
        check("req_raised", status(), {28'd0, ST_RQ});
        check("req_addr", bus.mem_rd_addr, exp_base);
        for (int k = 0; k < n_wait; k++) begin
            step();
            check("req_held", status(), {28'd0, ST_RQ});
            check("req_addr_held", bus.mem_rd_addr, exp_base);
        end
        bus.mem_rd_gnt = 1'b1;
        step();
        bus.mem_rd_gnt = 1'b0;
        check("burst_entry", status(), {28'd0, ST_BSY});
    endtask

    task automatic send_beats(input logic [31:0] data_base, input int first, input int count, input int gap_max);
        for (int i = first; i < first + count; i++) begin
            int gap;
            gap = $urandom_range(0, gap_max);
            for (int g = 0; g < gap; g++) begin
                step();
                check("burst_gap", status(), {28'd0, ST_BSY});
            end
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = data_base + 32'(i);
            exp_q.push_back(data_base + 32'(i));
            step();
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = '0;
            if (i != LW - 1) check("burst_beat", status(), {28'd0, ST_BSY});
        end
    endtask

    // Called in the cycle after the final beat.
    task automatic check_write(input logic [31:0] exp_base, input bit keep_miss, input logic [31:0] next_addr);
        logic [31:0] first_word;
        check("write_strobe", status(), {28'd0, ST_WR});
        check("line_addr", bus.line_addr, exp_base);
        check("line_words", 32'(exp_q.size()), 32'(LW));
        first_word = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
        for (int i = 0; i < LW; i++) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check($sformatf("line_word%0d", i), bus.line_data[i], e);
        end
        exp_q.delete();
        if (keep_miss) bus.miss_addr = next_addr;
        else           bus.miss_req  = 1'b0;
        step();
        check("hold_state", status(), {28'd0, ST_BSY});
        check("line_data_holds", bus.line_data[0], first_word);
        check("line_addr_holds", bus.line_addr, exp_base);
        step();
        check("idle_after_hold", status(), {28'd0, ST_Z});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        miss;
        logic [31:0] addr;
        logic        gnt;
        logic        valid;
        logic [31:0] data;
        logic [3:0]  e_st;
        logic [31:0] e_rdaddr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic m, input logic [31:0] a,
                                input logic g, input logic v, input logic [31:0] d,
                                input logic [3:0] st, input logic [31:0] ra);
        vec_t x;
        x.rst = r; x.miss = m; x.addr = a; x.gnt = g; x.valid = v; x.data = d;
        x.e_st = st; x.e_rdaddr = ra;
        return x;
    endfunction

    vec_t vecs[18];

    initial begin
        int cnt;
        bit saw_wr;
        idle_inputs();
        rst = 1'b1;

        vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[2]  = mk(0, 1, 32'h0001_0023, 0, 0, 32'h0,      ST_RQ, 32'h0001_0020);
        vecs[3]  = mk(0, 1, 32'h0001_0023, 0, 0, 32'h0,      ST_RQ, 32'h0001_0020);
        vecs[4]  = mk(0, 1, 32'h0001_0023, 0, 1, 32'hDEAD,   ST_RQ, 32'h0001_0020);
        vecs[5]  = mk(0, 1, 32'h0001_0023, 1, 0, 32'h0,      ST_BSY, 32'h0);
        vecs[6]  = mk(0, 1, 32'h0001_0023, 1, 0, 32'h0,      ST_BSY, 32'h0);
        vecs[7]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[8]  = mk(0, 1, 32'h0001_01FF, 0, 0, 32'h0,      ST_RQ, 32'h0001_01F0);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[10] = mk(0, 1, 32'h0001_0000, 0, 0, 32'h0,      ST_RQ, 32'h0001_0000);
        vecs[11] = mk(1, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[12] = mk(0, 1, 32'h0000_FFFF, 0, 0, 32'h0,      ST_ER, 32'h0);
        vecs[13] = mk(1, 0, 32'h0,         0, 0, 32'h0,      ST_Z,  32'h0);
        vecs[14] = mk(0, 1, 32'h0002_0000, 0, 0, 32'h0,      ST_ER, 32'h0);
        vecs[15] = mk(0, 1, 32'h0001_0023, 0, 0, 32'h0,      ST_ER, 32'h0);
        vecs[16] = mk(0, 1, 32'h0001_0023, 1, 1, 32'h1234,   ST_ER, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,         0, 0, 32'h0,      ST_ER, 32'h0);

        step();
        for (int i = 0; i < 18; i++) begin
            rst              = vecs[i].rst;
            bus.miss_req     = vecs[i].miss;
            bus.miss_addr    = vecs[i].addr;
            bus.mem_rd_gnt   = vecs[i].gnt;
            bus.mem_rd_valid = vecs[i].valid;
            bus.mem_rd_data  = vecs[i].data;
            step();
            check($sformatf("vec%0d_status", i), status(), {28'd0, vecs[i].e_st});
            if (vecs[i].e_st[3] || vecs[i].rst)
                check($sformatf("vec%0d_rd_addr", i), bus.mem_rd_addr, vecs[i].e_rdaddr);
        end

        // Nominal fill, grant after 2 cycles.
        do_reset();
        start_fill(32'h0001_0023, 32'h0001_0020, 1);
        send_beats(32'h0000_A000, 0, LW, 0);
        check_write(32'h0001_0020, 1'b0, 32'h0);

        // Gapped burst straight from IDLE, no reset between fills.
        start_fill(32'h0001_0047, 32'h0001_0040, 3);
        send_beats(32'h0000_C000, 0, LW, 10);
        check_write(32'h0001_0040, 1'b0, 32'h0);

        // Watchdog: a beat on the last permitted idle cycle is accepted,
        // then silence after beat 5 faults after exactly TIMEOUT cycles.
        start_fill(32'h0001_0155, 32'h0001_0150, 0);
        send_beats(32'h0000_D000, 0, 4, 0);
        for (int k = 0; k < TO - 1; k++) step();
        check("pre_boundary", status(), {28'd0, ST_BSY});
        send_beats(32'h0000_D000, 4, 1, 0);
        check("boundary_beat_ok", status(), {28'd0, ST_BSY});
        cnt = 0;
        saw_wr = 1'b0;
        while (!bus.fill_err && cnt < TO + 10) begin
            step();
            cnt++;
            if (bus.line_wr_en) saw_wr = 1'b1;
        end
        check("timeout_cycles", 32'(cnt), 32'(TO));
        check("timeout_no_write", {31'd0, saw_wr}, 32'd0);
        check("timeout_err", status(), {28'd0, ST_ER});
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0001_0000;
        step();
        check("err_sticky", status(), {28'd0, ST_ER});
        exp_q.delete();

        // Reset mid-burst after 7 beats, following a completed fill.
        do_reset();
        start_fill(32'h0001_0010, 32'h0001_0010, 0);
        send_beats(32'h0000_5000, 0, LW, 0);
        check_write(32'h0001_0010, 1'b0, 32'h0);
        start_fill(32'h0001_0066, 32'h0001_0060, 0);
        send_beats(32'h0000_E000, 0, 7, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_status", status(), {28'd0, ST_Z});
        check("async_rst_line_addr", bus.line_addr, 32'h0);
        check("async_rst_rd_addr", bus.mem_rd_addr, 32'h0);
        check("async_rst_line_data", {31'd0, |bus.line_data}, 32'd0);
        exp_q.delete();
        bus.miss_req = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 7; i < LW; i++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 32'h0000_E000 + 32'(i);
            step();
            check("late_beat_ignored", status(), {28'd0, ST_Z});
        end
        bus.mem_rd_valid = 1'b0;
        start_fill(32'h0001_0100, 32'h0001_0100, 1);
        send_beats(32'h0000_B000, 0, LW, 2);
        check_write(32'h0001_0100, 1'b0, 32'h0);

        // Back-to-back misses: miss held through HOLD.
        start_fill(32'h0001_0080, 32'h0001_0080, 0);
        send_beats(32'h0000_9000, 0, LW, 0);
        check_write(32'h0001_0080, 1'b1, 32'h0001_01A5);
        step();
        check("b2b_req", status(), {28'd0, ST_RQ});
        check("b2b_addr", bus.mem_rd_addr, 32'h0001_01A0);
        bus.mem_rd_gnt = 1'b1;
        step();
        bus.mem_rd_gnt = 1'b0;
        check("b2b_burst", status(), {28'd0, ST_BSY});
        send_beats(32'h0000_7700, 0, LW, 1);
        check_write(32'h0001_01A0, 1'b0, 32'h0);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
